// File: rtl/otn_frame_rec.sv
// otn_frame_rec: far-end OTN serial receiver.
// Oversamples the serial line, hunts for the FAS bitwise, deserializes the
// frame LSB first, checks the trailing BIP-8 byte and, when ARQ is enabled,
// returns a start/result/stop ACK on an idle-high serial line.
module otn_frame_rec #(
    parameter int unsigned CLKS_PER_BIT = 20,
    parameter int unsigned SAMPLE_PHASE = 9,
    parameter int unsigned FRAME_BYTES  = 4164,
    parameter logic [47:0] FAS          = 48'hF6F6F6282828,
    parameter int unsigned ACK_GAP_BITS = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_otn_rx_data,
    input  logic       i_arq_en,
    output logic       o_otn_tx_ack,
    output logic [7:0] o_byte_data,
    output logic       o_byte_valid,
    output logic       o_frame_fas,
    output logic       o_frame_done,
    output logic       o_frame_good,
    output logic [2:0] o_rr_state
);

    // FAS rearranged into line order: first transmitted byte in bits [7:0],
    // so a right-shifting register holding the last 48 bits compares directly.
    function automatic logic [47:0] fas_wire_order(input logic [47:0] p);
        logic [47:0] r;
        r = '0;
        for (int unsigned k = 0; k < 6; k++) begin
            r[8*k +: 8] = p[47-8*k -: 8];
        end
        return r;
    endfunction

    localparam int unsigned GAP_TICKS = ACK_GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned PH_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned TM_W      = $clog2(GAP_TICKS + 1);

    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [TM_W-1:0] GAP_LAST  = TM_W'(GAP_TICKS - 1);
    localparam logic [TM_W-1:0] BIT_LAST  = TM_W'(CLKS_PER_BIT - 1);
    localparam logic [12:0]     LAST_IDX  = 13'(FRAME_BYTES - 1);
    localparam logic [12:0]     FIRST_IDX = 13'd6;
    localparam logic [47:0]     FAS_WIRE  = fas_wire_order(FAS);

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_RECV  = 3'd1,
        ST_CHECK = 3'd2,
        ST_GAP   = 3'd3,
        ST_ACK   = 3'd4
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    logic [PH_W-1:0] phase;
    logic [47:0]     fas_sr;
    logic [7:0]      byte_sr;
    logic [2:0]      bit_cnt;
    logic [12:0]     byte_idx;
    logic [7:0]      bip_acc;
    logic [7:0]      bip_byte;
    logic [TM_W-1:0] timer;
    logic [1:0]      ack_bit;

    logic            rx_edge;
    logic            resync;
    logic            bit_strobe;
    logic [47:0]     fas_next;
    logic            fas_hit;
    logic [7:0]      byte_next;

    assign rx_edge    = rx_sync ^ rx_prev;
    assign resync     = rx_edge && ((state == ST_HUNT) || (state == ST_RECV));
    assign bit_strobe = i_sclk_en_16_x_baud && (phase == PH_SAMPLE);
    assign fas_next   = {rx_sync, fas_sr[47:1]};
    assign fas_hit    = (fas_next == FAS_WIRE);
    assign byte_next  = {rx_sync, byte_sr[7:1]};
    assign o_rr_state = state;

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b0;
            rx_sync <= 1'b0;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= i_otn_rx_data;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit-phase counter: wraps every CLKS_PER_BIT ticks, realigned by line edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase <= '0;
        end else if (resync) begin
            phase <= '0;
        end else if (i_sclk_en_16_x_baud) begin
            phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        end
    end

    // Receive/check/ACK state machine with registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_HUNT;
            fas_sr       <= '0;
            byte_sr      <= '0;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            bip_acc      <= '0;
            bip_byte     <= '0;
            timer        <= '0;
            ack_bit      <= '0;
            o_otn_tx_ack <= 1'b1;
            o_byte_data  <= '0;
            o_byte_valid <= 1'b0;
            o_frame_fas  <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_good <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_frame_fas  <= 1'b0;
            o_frame_done <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (bit_strobe) begin
                        fas_sr <= fas_next;
                        if (fas_hit) begin
                            o_frame_fas <= 1'b1;
                            byte_idx    <= FIRST_IDX;
                            bip_acc     <= '0;
                            bit_cnt     <= '0;
                            byte_sr     <= '0;
                            state       <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (bit_strobe) begin
                        byte_sr <= byte_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            o_byte_data  <= byte_next;
                            o_byte_valid <= 1'b1;
                            if (byte_idx == LAST_IDX) begin
                                bip_byte <= byte_next;
                                state    <= ST_CHECK;
                            end else begin
                                bip_acc  <= bip_acc ^ byte_next;
                                byte_idx <= byte_idx + 13'd1;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    o_frame_good <= (bip_acc == bip_byte);
                    o_frame_done <= 1'b1;
                    timer        <= '0;
                    ack_bit      <= '0;
                    if (i_arq_en) begin
                        state <= ST_GAP;
                    end else begin
                        fas_sr <= '0;
                        state  <= ST_HUNT;
                    end
                end
                ST_GAP: begin
                    o_otn_tx_ack <= 1'b1;
                    if (i_sclk_en_16_x_baud) begin
                        if (timer == GAP_LAST) begin
                            timer        <= '0;
                            o_otn_tx_ack <= 1'b0;
                            state        <= ST_ACK;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (i_sclk_en_16_x_baud) begin
                        if (timer == BIT_LAST) begin
                            timer <= '0;
                            case (ack_bit)
                                2'd0: begin
                                    o_otn_tx_ack <= o_frame_good;
                                    ack_bit      <= 2'd1;
                                end
                                2'd1: begin
                                    o_otn_tx_ack <= 1'b0;
                                    ack_bit      <= 2'd2;
                                end
                                default: begin
                                    o_otn_tx_ack <= 1'b1;
                                    ack_bit      <= 2'd0;
                                    fas_sr       <= '0;
                                    state        <= ST_HUNT;
                                end
                            endcase
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: doc/otn_frame_rec.md
Name: otn_frame_rec

Overview:
- Far-end receiver for the serial OTN link driven by the sender's transmit/retransmit block.
- Oversamples the serial line (one bit per CLKS_PER_BIT baud-enable ticks, bytes LSB first) and hunts for the FAS pattern bitwise.
- Deserializes each frame into bytes and checks a BIP-8 byte.
- When ARQ is enabled, returns a serial ACK (start/ack/stop) on the ACK line, which feeds the sender's i_otn_tx_ack.

Parameters:
- CLKS_PER_BIT, 20: i_sclk_en_16_x_baud ticks per serial bit.
- SAMPLE_PHASE, 9: phase count at which a bit is sampled (mid-bit).
- FRAME_BYTES, 4164: frame length in bytes, FAS included.
- FAS, 48'hF6F6F6282828: alignment pattern; byte k (first transmitted = 0) is FAS[47-8k -: 8].
- ACK_GAP_BITS, 4: bit periods of idle-high between end of frame and ACK start bit.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_sclk_en_16_x_baud  in  1  baud-rate enable tick.
- i_otn_rx_data  in  1  serial frame data from the link (asynchronous).
- i_arq_en  in  1  1 = send ACK after each frame; 0 = no ACK.
- o_otn_tx_ack  out  1  serial ACK line: idles high.
- o_byte_data  out  8  received byte after FAS.
- o_byte_valid  out  1  one-cycle strobe qualifying o_byte_data.
- o_frame_fas  out  1  one-cycle pulse on FAS match.
- o_frame_done  out  1  one-cycle pulse when the check result is known.
- o_frame_good  out  1  check result, valid with o_frame_done, held until the next o_frame_done.
- o_rr_state  out  3  current state, for debug LEDs.

Behaviour:
- Reset values:
  - o_otn_tx_ack=1; o_byte_data=0; o_byte_valid=0.
  - o_frame_fas=0; o_frame_done=0; o_frame_good=0.
  - State=HUNT.
  - All counters and shift registers 0.
  - Reset is asynchronous; mid-frame reset aborts the frame with no ACK and no done pulse.
- Input sync:
  - i_otn_rx_data passes through a 2-flop synchronizer on i_clk.
  - Edge detect uses the synchronized value.
- Bit timing:
  - Phase counter 0..CLKS_PER_BIT-1 advances on each tick and wraps.
  - In HUNT and RECV, any synchronized edge forces phase to 0 on that cycle.
  - A bit is sampled when tick && phase==SAMPLE_PHASE.
- States (o_rr_state encoding):
  - HUNT=0:
    - Each sampled bit enters bit 47 of a 48-bit shift register, which shifts right.
    - On match (reg[8k+7:8k]==FAS byte k for k=0..5), pulse o_frame_fas, set byte index=6, clear BIP accumulator and bit counter, go to RECV.
  - RECV=1:
    - Sampled bits assemble LSB first; after 8th bit, o_byte_data/o_byte_valid asserted the next cycle.
    - Bytes with index 6..FRAME_BYTES-2 are XORed into the BIP accumulator.
    - Byte FRAME_BYTES-1 is the BIP byte: stored, and it still produces o_byte_valid.
    - After it, go to CHECK.
  - CHECK=2, one cycle:
    - o_frame_good = (accumulator == BIP byte); o_frame_done pulses.
    - Next state is GAP if i_arq_en, else HUNT.
  - GAP=3:
    - o_otn_tx_ack=1; bit timer counts ACK_GAP_BITS*CLKS_PER_BIT ticks (no edge resync), then go to ACK.
  - ACK=4:
    - Three bit periods, CLKS_PER_BIT ticks each: start=0, then o_frame_good, then stop=0.
    - Then o_otn_tx_ack=1 and go to HUNT with the shift register cleared.
- The FAS shift register runs only in HUNT; a FAS-like pattern inside a payload is ignored.
- Line activity during GAP/ACK is ignored.
- i_arq_en is sampled only in CHECK.
- Counters:
  - Byte index is 13 bits; the bit counter is 3 bits and wraps 7→0 at each byte.
  - With no ticks, nothing advances, and outputs hold except the strobes, which are low.

Test Plan:
- Clean frame:
  - Stimulus: FRAME_BYTES=16 override; serial frame = FAS + 9 payload bytes 0x01..0x09 + BIP 0x01, 20 ticks/bit, i_arq_en=1.
  - Required: o_frame_fas once; 10 o_byte_valid strobes with data 0x01..0x09,0x01; o_frame_done with o_frame_good=1.
  - Then o_otn_tx_ack stays high for 80 ticks, then 0,1,0 for 20 ticks each, then high.
- Corrupted frame: same frame with payload byte 0x05 sent as 0x04 → o_frame_good=0; ACK bit sequence 0,0,0.
- ARQ disabled: i_arq_en=0, clean frame → o_frame_done with good=1; o_otn_tx_ack constant 1; state returns to HUNT one cycle after CHECK.
- Alignment hunt: 37 random bits, then a partial FAS (F6 F6 F6 28 28 00), then a full frame → exactly one o_frame_fas, aligned to the full FAS; payload bytes correct.
- Reset mid-frame: assert i_rst_n=0 after byte index 8, release, send a clean frame → no done/ACK for the aborted frame; the second frame is acknowledged good.
- Phase drift: send a clean frame at 21 ticks/bit → edge resync keeps sampling correct; o_frame_good=1.
